// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants: screen geometry, coordinate/colour widths,
// RGB333 colour names and the rectangle filler state encoding.
package vga_pkg;
  localparam int unsigned XSCREEN = 640;
  localparam int unsigned YSCREEN = 480;
  localparam int unsigned COLOR_W = 9;
  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;

  localparam logic [COLOR_W-1:0] BLACK = 9'h000;
  localparam logic [COLOR_W-1:0] WHITE = 9'h1FF;
  localparam logic [COLOR_W-1:0] RED   = 9'h1C0;
  localparam logic [COLOR_W-1:0] GREEN = 9'h038;
  localparam logic [COLOR_W-1:0] BLUE  = 9'h007;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } fill_state_t;
endpackage

// File: rtl/refresh_timer.sv
// Auto-refresh interval counter with a single pending flag; counts only while
// enabled, INTERVAL of 0 disables it. Expiries while already pending are dropped.
module refresh_timer #(
  parameter int unsigned INTERVAL = 5_000_000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic enable,
  input  logic clear,
  output logic pending
);
  localparam int unsigned CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((INTERVAL > 0) ? INTERVAL - 1 : 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (!Resetn || !enable || INTERVAL == 0) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (cnt == LAST) begin
      // A fresh expiry outranks a same-cycle accept so the request is not lost.
      cnt     <= '0;
      pending <= 1'b1;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (clear)
        pending <= 1'b0;
    end
  end
endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle filler for the VGA write port: host jobs plus periodic auto-refresh.
// Define RECT_FILL_CLIP_EN to clamp rectangles to the screen; otherwise they wrap.
module rect_fill_engine #(
  parameter int unsigned XSCREEN          = vga_pkg::XSCREEN,
  parameter int unsigned YSCREEN          = vga_pkg::YSCREEN,
  parameter int unsigned COLOR_W          = vga_pkg::COLOR_W,
  parameter int unsigned REFRESH_INTERVAL = 5_000_000,
  parameter int unsigned AUTO_X0          = 120,
  parameter int unsigned AUTO_Y0          = 0,
  parameter int unsigned AUTO_W           = 400,
  parameter int unsigned AUTO_H           = 80,
  parameter logic [COLOR_W-1:0] AUTO_COLOR = '0
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    enable,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [vga_pkg::X_W-1:0] req_x,
  input  logic [vga_pkg::Y_W-1:0] req_y,
  input  logic [vga_pkg::X_W-1:0] req_w,
  input  logic [vga_pkg::Y_W-1:0] req_h,
  input  logic [COLOR_W-1:0]      req_color,
  output logic                    busy,
  output logic                    done,
  output logic [vga_pkg::X_W-1:0] VGA_x,
  output logic [vga_pkg::Y_W-1:0] VGA_y,
  output logic [COLOR_W-1:0]      VGA_color,
  output logic                    VGA_write,
  input  logic                    VGA_ready
);
  import vga_pkg::*;

  localparam logic [X_W:0]   XS  = (X_W+1)'(XSCREEN);
  localparam logic [Y_W:0]   YS  = (Y_W+1)'(YSCREEN);
  localparam logic [X_W-1:0] AX0 = X_W'(AUTO_X0);
  localparam logic [Y_W-1:0] AY0 = Y_W'(AUTO_Y0);
  localparam logic [X_W-1:0] AW  = X_W'(AUTO_W);
  localparam logic [Y_W-1:0] AH  = Y_W'(AUTO_H);

  fill_state_t        state;
  logic [X_W:0]       cx, x_org, x_end, cx_nxt, x_end_n;
  logic [Y_W:0]       cy, y_end, cy_nxt, y_end_n;
  logic [X_W-1:0]     src_x, src_w;
  logic [Y_W-1:0]     src_y, src_h;
  logic [COLOR_W-1:0] src_c;
  logic               write_q, busy_q, done_q;
  logic               pending, host_acc, auto_acc, zero_area;

  function automatic logic [X_W-1:0] wrap_x(input logic [X_W:0] v);
    logic [X_W:0] r;
    r = (v >= XS) ? v - XS : v;
    return r[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] wrap_y(input logic [Y_W:0] v);
    logic [Y_W:0] r;
    r = (v >= YS) ? v - YS : v;
    return r[Y_W-1:0];
  endfunction

  assign req_ready = (state == IDLE) && enable;
  assign host_acc  = req_valid && req_ready;
  assign auto_acc  = req_ready && pending && !req_valid;

  assign VGA_write = write_q && enable;
  assign busy      = busy_q && enable;
  assign done      = done_q && enable;

  assign cx_nxt = cx + (X_W+1)'(1);
  assign cy_nxt = cy + (Y_W+1)'(1);

  refresh_timer #(
    .INTERVAL(REFRESH_INTERVAL)
  ) u_refresh (
    .Clock  (Clock),
    .Resetn (Resetn),
    .enable (enable),
    .clear  (auto_acc),
    .pending(pending)
  );

  always_comb begin
    src_x = host_acc ? req_x     : AX0;
    src_y = host_acc ? req_y     : AY0;
    src_w = host_acc ? req_w     : AW;
    src_h = host_acc ? req_h     : AH;
    src_c = host_acc ? req_color : AUTO_COLOR;
    x_end_n = {1'b0, src_x} + {1'b0, src_w};
    y_end_n = {1'b0, src_y} + {1'b0, src_h};
`ifdef RECT_FILL_CLIP_EN
    if (x_end_n > XS) x_end_n = XS;
    if (y_end_n > YS) y_end_n = YS;
`endif
    // Covers w==0, h==0 and, when clamped, an origin at or past the edge.
    zero_area = (x_end_n <= {1'b0, src_x}) || (y_end_n <= {1'b0, src_y});
  end

  always_ff @(posedge Clock) begin
    if (!Resetn || !enable) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      x_org     <= '0;
      x_end     <= '0;
      y_end     <= '0;
      VGA_x     <= '0;
      VGA_y     <= '0;
      VGA_color <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (host_acc || auto_acc) begin
            x_org     <= {1'b0, src_x};
            x_end     <= x_end_n;
            y_end     <= y_end_n;
            cx        <= {1'b0, src_x};
            cy        <= {1'b0, src_y};
            VGA_x     <= wrap_x({1'b0, src_x});
            VGA_y     <= wrap_y({1'b0, src_y});
            VGA_color <= src_c;
            busy_q    <= 1'b1;
            if (zero_area) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= DRAW;
              write_q <= 1'b1;
            end
          end
        end
        DRAW: begin
          if (VGA_ready) begin
            if (cx_nxt != x_end) begin
              cx    <= cx_nxt;
              VGA_x <= wrap_x(cx_nxt);
            end else if (cy_nxt != y_end) begin
              cx    <= x_org;
              cy    <= cy_nxt;
              VGA_x <= wrap_x(x_org);
              VGA_y <= wrap_y(cy_nxt);
            end else begin
              write_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: expected pixels are queued by the
// stimulus and popped by a monitor on every write handshake.
module tb_rect_fill_engine;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] c;
  } pix_t;

  localparam logic [8:0] AC = 9'h0A5;

  logic       Clock = 1'b0;
  logic       Resetn, enable, req_valid, req_ready, busy, done, VGA_write, VGA_ready;
  logic [9:0] req_x, req_w, VGA_x;
  logic [8:0] req_y, req_h, VGA_y, req_color, VGA_color;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  pix_t exp_q[$];

  always #5 Clock = ~Clock;

  rect_fill_engine #(
    .REFRESH_INTERVAL(20),
    .AUTO_X0(300),
    .AUTO_Y0(200),
    .AUTO_W(4),
    .AUTO_H(2),
    .AUTO_COLOR(AC)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_color(req_color),
    .busy(busy), .done(done),
    .VGA_x(VGA_x), .VGA_y(VGA_y), .VGA_color(VGA_color),
    .VGA_write(VGA_write), .VGA_ready(VGA_ready)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input int x, input int y, input logic [8:0] c);
    pix_t p;
    p.x = 10'(x);
    p.y = 9'(y);
    p.c = c;
    exp_q.push_back(p);
  endtask

  task automatic push_refresh();
    for (int yy = 200; yy < 202; yy++)
      for (int xx = 300; xx < 304; xx++)
        push(xx, yy, AC);
  endtask

  // Returns at the sample just after the accepting edge.
  task automatic host_job(input int x, input int y, input int w, input int h, input logic [8:0] c);
    bit ok;
    ok = 1'b0;
    req_x = 10'(x); req_y = 9'(y); req_w = 10'(w); req_h = 9'(h); req_color = c;
    req_valid = 1'b1;
    #1;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (req_ready) ok = 1'b1;
      step();
    end
    req_valid = 1'b0;
    check("accept", ok, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check({name, "_done"}, done, 1'b1);
    exp_done++;
    step();
    check({name, "_done_pulse"}, done, 1'b0);
    check({name, "_ready_after"}, req_ready, 1'b1);
  endtask

  task automatic idle_gap();
    enable = 1'b0;
    step();
    step();
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    pix_t cur, held, e;
    logic hold_v;
    hold_v = 1'b0;
    forever begin
      @(negedge Clock);
      cur = '{x: VGA_x, y: VGA_y, c: VGA_color};
      if (Resetn && enable && hold_v)
        check("hold", {VGA_write, cur}, {1'b1, held});
      if (Resetn && VGA_write && VGA_ready) begin
        if (exp_q.size() == 0) begin
          check("pix_extra", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("pixel", cur, e);
        end
      end
      hold_v = Resetn && VGA_write && !VGA_ready;
      held   = cur;
      if (done) done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int first;
    Resetn = 1'b0; enable = 1'b0; req_valid = 1'b0; VGA_ready = 1'b1;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_color = '0;
    repeat (3) step();
    check("rst_write", VGA_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_xyc", {VGA_x, VGA_y, VGA_color}, '0);

    // Refresh fires on its own 20 cycles after reset.
    push_refresh();
    Resetn = 1'b1;
    enable = 1'b1;
    first = 0;
    for (int n = 1; n <= 40 && first == 0; n++) begin
      step();
      if (VGA_write) first = n;
    end
    check("refresh_start", first, 21);
    check("refresh_busy", busy, 1'b1);
    wait_done("refresh");
    idle_gap();

    // Host request arriving with the refresh expiry wins; refresh follows.
    for (int yy = 5; yy < 7; yy++)
      for (int xx = 10; xx < 13; xx++)
        push(xx, yy, 9'h1FF);
    push_refresh();
    enable = 1'b1;
    repeat (20) step();
    check("collide_idle", VGA_write, 1'b0);
    host_job(10, 5, 3, 2, 9'h1FF);
    wait_done("host_first");
    wait_done("refresh_after");
    idle_gap();

    // Backpressure mid-job.
    for (int yy = 50; yy < 52; yy++)
      for (int xx = 100; xx < 103; xx++)
        push(xx, yy, 9'h0F0);
    enable = 1'b1;
    host_job(100, 50, 3, 2, 9'h0F0);
    step();
    step();
    VGA_ready = 1'b0;
    repeat (4) step();
    check("stall_write", VGA_write, 1'b1);
    VGA_ready = 1'b1;
    wait_done("stall");
    idle_gap();

    // Zero width: no writes, done at T+1, ready at T+2.
    enable = 1'b1;
    host_job(5, 5, 0, 3, 9'h111);
    check("w0_done_t1", done, 1'b1);
    check("w0_nowrite", VGA_write, 1'b0);
    check("w0_busy_ready", req_ready, 1'b0);
    exp_done++;
    step();
    check("w0_done_t2", done, 1'b0);
    check("w0_ready_t2", req_ready, 1'b1);
    idle_gap();

    // Screen-edge rectangle.
`ifdef RECT_FILL_CLIP_EN
    push(638, 479, 9'h1C7);
    push(639, 479, 9'h1C7);
`else
    begin
      int xs[4];
      int ys[4];
      xs = '{638, 639, 0, 1};
      ys = '{479, 0, 1, 2};
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          push(xs[k], ys[r], 9'h1C7);
    end
`endif
    enable = 1'b1;
    host_job(638, 479, 4, 4, 9'h1C7);
    wait_done("edge");
    idle_gap();

    // Enable dropped mid-job: write and busy fall at once, no done.
    push(200, 100, 9'h155);
    push(201, 100, 9'h155);
    push(202, 100, 9'h155);
    enable = 1'b1;
    host_job(200, 100, 5, 2, 9'h155);
    repeat (3) step();
    check("abort_pre_write", VGA_write, 1'b1);
    enable = 1'b0;
    #1;
    check("abort_write", VGA_write, 1'b0);
    check("abort_busy", busy, 1'b0);
    step();
    check("abort_done", done, 1'b0);
    push(200, 100, 9'h155);
    push(201, 100, 9'h155);
    enable = 1'b1;
    host_job(200, 100, 2, 1, 9'h155);
    wait_done("restart");
    idle_gap();

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
